// File: rtl/blackjack_pkg.sv
// Shared card-game definitions: deck geometry, card field widths and dealer FSM states.
package blackjack_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned NUM_RANKS = 13;
  localparam int unsigned NUM_SUITS = 4;

  localparam int unsigned IDX_W  = 6;
  localparam int unsigned RANK_W = 4;
  localparam int unsigned SUIT_W = 2;

  typedef enum logic {
    IDLE,
    PROBE
  } dealer_state_t;

endpackage

// File: rtl/rng.sv
// Stateless xorshift32 next-state logic; the caller owns the state register.
module rng (
  input  logic [31:0] current,
  output logic [31:0] rng_next
);

  logic [31:0] s1;
  logic [31:0] s2;

  always_comb begin
    s1       = current ^ (current << 13);
    s2       = s1 ^ (s1 >> 17);
    rng_next = s2 ^ (s2 << 5);
  end

endmodule

// File: rtl/card_dealer.sv
// Deals cards without replacement from a 52-card deck, probing linearly past dealt cards.
// Optional: define CARD_DEALER_AUTO_SHUFFLE_EN to refill the deck on a deal request when empty.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter logic [31:0] SEED      = 32'd1,
  parameter int unsigned DECK_SIZE = 52
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              deal_req,
  input  logic              shuffle_req,
  input  logic              seed_load,
  input  logic [31:0]       seed_in,
  output logic              busy,
  output logic              card_valid,
  output logic [IDX_W-1:0]  card_idx,
  output logic [RANK_W-1:0] card_rank,
  output logic [SUIT_W-1:0] card_suit,
  output logic [IDX_W-1:0]  cards_left,
  output logic              deck_empty,
  output logic              deal_err
);

  dealer_state_t        state;
  logic [31:0]          rng_state;
  logic [31:0]          rng_next;
  logic [DECK_SIZE-1:0] dealt_mask;
  logic [IDX_W-1:0]     probe;
  logic [IDX_W-1:0]     start_probe;
  logic [IDX_W-1:0]     rank0;

  rng u_rng (
    .current  (rng_state),
    .rng_next (rng_next)
  );

  always_comb begin
    start_probe = IDX_W'(rng_next % DECK_SIZE);
    rank0       = probe % IDX_W'(NUM_RANKS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rng_state  <= SEED;
      dealt_mask <= '0;
      probe      <= '0;
      busy       <= 1'b0;
      card_valid <= 1'b0;
      card_idx   <= '0;
      card_rank  <= '0;
      card_suit  <= '0;
      cards_left <= IDX_W'(DECK_SIZE);
      deck_empty <= 1'b0;
      deal_err   <= 1'b0;
    end else begin
      card_valid <= 1'b0;
      deal_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (shuffle_req) begin
            dealt_mask <= '0;
            cards_left <= IDX_W'(DECK_SIZE);
            deck_empty <= 1'b0;
          end else if (seed_load) begin
            rng_state <= (seed_in == '0) ? 32'd1 : seed_in;
          end else if (deal_req) begin
            // The refill and the deal start share this cycle; PROBE sees the cleared mask.
`ifdef CARD_DEALER_AUTO_SHUFFLE_EN
            if (cards_left == '0) begin
              dealt_mask <= '0;
              cards_left <= IDX_W'(DECK_SIZE);
              deck_empty <= 1'b0;
            end
`else
            if (cards_left == '0) deal_err <= 1'b1;
            else
`endif
            begin
              rng_state <= rng_next;
              probe     <= start_probe;
              busy      <= 1'b1;
              state     <= PROBE;
            end
          end
        end
        PROBE: begin
          if (!dealt_mask[probe]) begin
            dealt_mask[probe] <= 1'b1;
            card_idx          <= probe;
            card_rank         <= RANK_W'(rank0) + RANK_W'(1);
            card_suit         <= SUIT_W'(probe / IDX_W'(NUM_RANKS));
            cards_left        <= cards_left - IDX_W'(1);
            deck_empty        <= (cards_left == IDX_W'(1));
            card_valid        <= 1'b1;
            busy              <= 1'b0;
            state             <= IDLE;
          end else begin
            probe <= (probe == IDX_W'(DECK_SIZE - 1)) ? '0 : probe + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: deck-level reference model compared every cycle, plus directed scenarios.
module tb_card_dealer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        deal_req = 1'b0;
  logic        shuffle_req = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed_in = '0;
  logic        busy;
  logic        card_valid;
  logic [5:0]  card_idx;
  logic [3:0]  card_rank;
  logic [1:0]  card_suit;
  logic [5:0]  cards_left;
  logic        deck_empty;
  logic        deal_err;

  int n_cmp = 0;
  int n_bad = 0;

  card_dealer #(.SEED(32'd1), .DECK_SIZE(52)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .deal_req    (deal_req),
    .shuffle_req (shuffle_req),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .busy        (busy),
    .card_valid  (card_valid),
    .card_idx    (card_idx),
    .card_rank   (card_rank),
    .card_suit   (card_suit),
    .cards_left  (cards_left),
    .deck_empty  (deck_empty),
    .deal_err    (deal_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: deck as a used-card array; a deal resolves to its card and
  // completion delay at acceptance time.
  logic [31:0] m_rng;
  bit          m_used[52];
  int          m_left;
  bit          m_busy;
  int          m_wait;
  int          m_pend;
  bit          m_valid;
  bit          m_err;
  int          m_idx;
  bit          m_go;
  int          m_start;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rng = 32'd1;
      foreach (m_used[i]) m_used[i] = 1'b0;
      m_left = 52; m_busy = 0; m_wait = 0; m_pend = 0;
      m_valid = 0; m_err = 0; m_idx = 0;
    end else begin
      m_valid = 0;
      m_err   = 0;
      if (m_busy) begin
        m_wait--;
        if (m_wait == 0) begin
          m_used[m_pend] = 1'b1;
          m_idx   = m_pend;
          m_left--;
          m_valid = 1;
          m_busy  = 0;
        end
      end else if (shuffle_req) begin
        foreach (m_used[i]) m_used[i] = 1'b0;
        m_left = 52;
      end else if (seed_load) begin
        m_rng = (seed_in == 0) ? 32'd1 : seed_in;
      end else if (deal_req) begin
        m_go = 1;
        if (m_left == 0) begin
`ifdef CARD_DEALER_AUTO_SHUFFLE_EN
          foreach (m_used[i]) m_used[i] = 1'b0;
          m_left = 52;
`else
          m_err = 1;
          m_go  = 0;
`endif
        end
        if (m_go) begin
          m_rng   = xs(m_rng);
          m_start = int'(m_rng % 32'd52);
          for (int k = 0; k < 52; k++) begin
            if (!m_used[(m_start + k) % 52]) begin
              m_pend = (m_start + k) % 52;
              m_wait = k + 1;
              break;
            end
          end
          m_busy = 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #3;
    if (rst_n) begin
      chk("busy", busy, m_busy);
      chk("card_valid", card_valid, m_valid);
      chk("deal_err", deal_err, m_err);
      chk("card_idx", card_idx, m_idx);
      chk("card_rank", card_rank, m_idx % 13 + 1 - ((m_idx == 0 && !m_used_any()) ? 1 : 0));
      chk("card_suit", card_suit, m_idx / 13);
      chk("cards_left", cards_left, m_left);
      chk("deck_empty", deck_empty, m_left == 0);
    end
  end

  // Rank reads 0 only while nothing has been dealt since reset (all card outputs at reset value).
  bit m_dealt_since_reset;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_dealt_since_reset <= 1'b0;
    else if (card_valid) m_dealt_since_reset <= 1'b1;
  end
  function automatic bit m_used_any();
    return m_dealt_since_reset;
  endfunction

  task automatic do_deal(output int idx);
    bit found;
    found = 0;
    idx = -1;
    @(negedge clk); deal_req = 1'b1;
    @(negedge clk); deal_req = 1'b0;
    for (int lat = 1; lat <= 60; lat++) begin
      @(posedge clk); #3;
      if (card_valid) begin
        found = 1;
        idx = int'(card_idx);
        chk("deal_latency_le53", lat <= 53, 1);
        break;
      end
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL deal_timeout: got no card_valid expected card_valid within 53 cycles");
    end
  endtask

  task automatic do_shuffle();
    @(negedge clk); shuffle_req = 1'b1;
    @(negedge clk); shuffle_req = 1'b0;
  endtask

  task automatic do_seed(input logic [31:0] s);
    @(negedge clk); seed_load = 1'b1; seed_in = s;
    @(negedge clk); seed_load = 1'b0;
  endtask

  initial begin
    int idx, saved, missing;
    bit seen[52];

    // Model pins: xorshift32 from 1, and the first card it selects.
    chk("xs_of_1", xs(32'd1), 32'h0004_2021);
    chk("xs_of_42021", xs(32'h0004_2021), 32'h0408_0601);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cards_left", cards_left, 52);
    chk("rst_deck_empty", deck_empty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_card_valid", card_valid, 0);
    chk("rst_card_idx", card_idx, 0);

    // Full deck from seed 1
    foreach (seen[i]) seen[i] = 0;
    for (int i = 0; i < 52; i++) begin
      do_deal(idx);
      if (i == 0) chk("first_card_seed1", idx, 21);
      if (i == 1) chk("second_card_seed1", idx, 5);
      chk("idx_range", (idx >= 0 && idx < 52), 1);
      if (idx >= 0 && idx < 52) begin
        chk("idx_distinct", seen[idx], 0);
        seen[idx] = 1;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    chk("full_cards_left", cards_left, 0);
    chk("full_deck_empty", deck_empty, 1);

    // Empty deck request
`ifdef CARD_DEALER_AUTO_SHUFFLE_EN
    do_deal(idx);
    chk("auto_cards_left", cards_left, 51);
    chk("auto_no_err", deal_err, 0);
`else
    @(negedge clk); deal_req = 1'b1;
    @(negedge clk); deal_req = 1'b0;
    chk("empty_deal_err", deal_err, 1);
    repeat (4) begin
      @(posedge clk); #3;
      chk("empty_no_valid", card_valid, 0);
    end
`endif

    // Priority: shuffle wins over a simultaneous deal
    do_shuffle();
    for (int i = 0; i < 10; i++) do_deal(idx);
    saved = int'(card_idx);
    @(negedge clk); shuffle_req = 1'b1; deal_req = 1'b1;
    @(negedge clk); shuffle_req = 1'b0; deal_req = 1'b0;
    repeat (4) begin
      @(posedge clk); #3;
      chk("prio_no_valid", card_valid, 0);
      chk("prio_idx_held", card_idx, saved);
    end
    chk("prio_cards_left", cards_left, 52);

    // Zero seed loads 1
    do_seed(32'd0);
    do_deal(idx);
    chk("seed0_card", idx, 21);

    // Last card of a deck with a random seed
    do_seed($urandom | 32'd1);
    do_shuffle();
    foreach (seen[i]) seen[i] = 0;
    for (int i = 0; i < 51; i++) begin
      do_deal(idx);
      if (idx >= 0 && idx < 52) seen[idx] = 1;
    end
    missing = -1;
    foreach (seen[i]) if (!seen[i]) missing = i;
    do_deal(idx);
    chk("last_card_idx", idx, missing);
    chk("last_cards_left", cards_left, 0);

    // Reset while probing
    do_shuffle();
    for (int i = 0; i < 40; i++) do_deal(idx);
    @(negedge clk); deal_req = 1'b1;
    @(negedge clk); deal_req = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_cards_left", cards_left, 52);
    chk("midrst_card_valid", card_valid, 0);
    chk("midrst_card_idx", card_idx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_deal(idx);
    chk("midrst_first_card", idx, 21);

    // Random request traffic
    repeat (600) begin
      @(negedge clk);
      deal_req    = ($urandom_range(0, 99) < 45);
      shuffle_req = ($urandom_range(0, 99) < 3);
      seed_load   = ($urandom_range(0, 99) < 4);
      seed_in     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    end
    @(negedge clk);
    deal_req = 0; shuffle_req = 0; seed_load = 0;
    repeat (60) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
